// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package hazard_ctrl_pkg;

    localparam int REG_ADDR_LEN = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b10,
        FWD_MEMWB = 2'b01
    } fwd_e;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// rtl/hazard_ctrl_forward_unit.sv - EX operand bypass select for one source register
module forward_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_LEN-1:0] src_i,
    input  logic                    mem_reg_write_i,
    input  logic [REG_ADDR_LEN-1:0] mem_waddr_i,
    input  logic                    wb_reg_write_i,
    input  logic [REG_ADDR_LEN-1:0] wb_waddr_i,
    output fwd_e                    fwd_o
);

    // The younger producer in MEM wins over the older one in WB; r0 is never bypassed.
    always_comb begin
        fwd_o = FWD_REG;
        if (mem_reg_write_i && (mem_waddr_i != '0) && (mem_waddr_i == src_i)) begin
            fwd_o = FWD_EXMEM;
        end else if (wb_reg_write_i && (wb_waddr_i != '0) && (wb_waddr_i == src_i)) begin
            fwd_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward control with data-memory wait FSM and perf counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_LEN-1:0] id_rs,
    input  logic [REG_ADDR_LEN-1:0] id_rt,
    input  logic                    id_uses_rs,
    input  logic                    id_uses_rt,
    input  logic                    id_jump,
    input  logic [REG_ADDR_LEN-1:0] ex_rs,
    input  logic [REG_ADDR_LEN-1:0] ex_rt,
    input  logic                    ex_mem_read,
    input  logic [REG_ADDR_LEN-1:0] ex_waddr,
    input  logic                    ex_branch_taken,
    input  logic                    mem_reg_write,
    input  logic [REG_ADDR_LEN-1:0] mem_waddr,
    input  logic                    wb_reg_write,
    input  logic [REG_ADDR_LEN-1:0] wb_waddr,
    input  logic                    mem_req,
    input  logic                    dmem_ack,
    output logic                    pc_en,
    output logic                    ifid_en,
    output logic                    idex_en,
    output logic                    exmem_en,
    output logic                    memwb_en,
    output logic                    ifid_flush,
    output logic                    idex_flush,
    output logic [1:0]              fwd_a,
    output logic [1:0]              fwd_b,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic [CNT_W-1:0]        flush_count,
    output logic                    mem_timeout
);

    localparam int unsigned WAIT_W = $clog2(WAIT_LIMIT + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0]    flush_q, flush_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout_q, timeout_d;
    logic                in_wait;
    logic                freeze;
    logic                load_use;
    fwd_e                fwd_a_w, fwd_b_w;

    forward_unit u_fwd_a (
        .src_i           (ex_rs),
        .mem_reg_write_i (mem_reg_write),
        .mem_waddr_i     (mem_waddr),
        .wb_reg_write_i  (wb_reg_write),
        .wb_waddr_i      (wb_waddr),
        .fwd_o           (fwd_a_w)
    );

    forward_unit u_fwd_b (
        .src_i           (ex_rt),
        .mem_reg_write_i (mem_reg_write),
        .mem_waddr_i     (mem_waddr),
        .wb_reg_write_i  (wb_reg_write),
        .wb_waddr_i      (wb_waddr),
        .fwd_o           (fwd_b_w)
    );

    assign fwd_a = rst ? fwd_a_w : FWD_REG;
    assign fwd_b = rst ? fwd_b_w : FWD_REG;

    assign in_wait  = (state_q == MEM_WAIT) && !dmem_ack;
    assign freeze   = in_wait || ((state_q == RUN) && mem_req && !dmem_ack);
    assign load_use = ex_mem_read && (ex_waddr != '0) &&
                      ((id_uses_rs && (id_rs == ex_waddr)) || (id_uses_rt && (id_rt == ex_waddr)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_req && !dmem_ack) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ack) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Held in reset the pipeline free-runs; the freeze path only applies once out of reset.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (rst) begin
            if (freeze) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end else if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (id_jump) begin
                ifid_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (stall_q != '1)) stall_d = stall_q + 1'b1;
        flush_d = flush_q;
        if ((ifid_flush || idex_flush) && (flush_q != '1)) flush_d = flush_q + 1'b1;
        wait_d = '0;
        if (in_wait) begin
            wait_d = wait_q;
            if (wait_q != WAIT_W'(WAIT_LIMIT)) wait_d = wait_q + 1'b1;
        end
        timeout_d = timeout_q || (in_wait && (wait_d == WAIT_W'(WAIT_LIMIT)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            stall_q   <= '0;
            flush_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_waddr, mem_waddr, wb_waddr;
    logic       id_uses_rs, id_uses_rt, id_jump, ex_mem_read, ex_branch_taken;
    logic       mem_reg_write, wb_reg_write, mem_req, dmem_ack;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cycles, flush_count;
    logic       mem_timeout;
    logic [4:0] en;
    logic [1:0] fl;

    int checks = 0;
    int errors = 0;

    assign en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign fl = {ifid_flush, idex_flush};

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(4), .WAIT_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
        .ex_waddr(ex_waddr), .ex_branch_taken(ex_branch_taken),
        .mem_reg_write(mem_reg_write), .mem_waddr(mem_waddr),
        .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr),
        .mem_req(mem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .mem_timeout(mem_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_waddr = 0; mem_waddr = 0; wb_waddr = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_jump = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_reg_write = 0; wb_reg_write = 0; mem_req = 0; dmem_ack = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        ex_mem_read = 1; ex_waddr = 8; id_rs = 8; id_uses_rs = 1;
    endtask

    initial begin
        clr();
        rst = 0;
        mem_req = 1; ex_rs = 5; mem_reg_write = 1; mem_waddr = 5;
        #2;
        check("rst_en", 32'(en), 32'h1f);
        check("rst_fl", 32'(fl), 32'h0);
        check("rst_fwd", 32'(fwd_a), 32'h0);
        check("rst_stall", 32'(stall_cycles), 32'h0);
        check("rst_flushcnt", 32'(flush_count), 32'h0);
        check("rst_timeout", 32'(mem_timeout), 32'h0);
        clr();
        @(negedge clk);
        rst = 1;
        tick();

        #1;
        check("norm_en", 32'(en), 32'h1f);
        check("norm_fl", 32'(fl), 32'h0);

        set_lu(); #1;
        check("lu_en", 32'(en), 32'h07);
        check("lu_fl", 32'(fl), 32'h1);
        tick(); clr(); #1;
        check("lu_stall", 32'(stall_cycles), 32'd1);
        check("lu_once_en", 32'(en), 32'h1f);

        ex_mem_read = 1; ex_waddr = 8; id_rs = 3; id_rt = 8; id_uses_rs = 1; id_uses_rt = 1; #1;
        check("lu_rt_en", 32'(en), 32'h07);
        tick(); clr(); #1;
        check("lu_rt_stall", 32'(stall_cycles), 32'd2);

        ex_mem_read = 1; ex_waddr = 0; id_rs = 0; id_uses_rs = 1; #1;
        check("lu_r0_en", 32'(en), 32'h1f);
        ex_waddr = 8; id_rs = 8; id_uses_rs = 0; #1;
        check("lu_unused_en", 32'(en), 32'h1f);
        tick(); clr(); #1;
        check("nolu_stall", 32'(stall_cycles), 32'd2);
        check("nolu_flush", 32'(flush_count), 32'd2);

        set_lu(); ex_branch_taken = 1; #1;
        check("br_en", 32'(en), 32'h1f);
        check("br_fl", 32'(fl), 32'h3);
        tick(); clr(); #1;
        check("br_flush", 32'(flush_count), 32'd3);
        check("br_stall", 32'(stall_cycles), 32'd2);

        id_jump = 1; #1;
        check("jmp_fl", 32'(fl), 32'h2);
        check("jmp_en", 32'(en), 32'h1f);
        tick(); #1;
        check("jmp_flush", 32'(flush_count), 32'd4);
        set_lu(); #1;
        check("jmp_lu_en", 32'(en), 32'h07);
        check("jmp_lu_fl", 32'(fl), 32'h1);
        tick(); clr(); #1;
        check("jmp_lu_stall", 32'(stall_cycles), 32'd3);
        check("jmp_lu_flush", 32'(flush_count), 32'd5);

        mem_reg_write = 1; mem_waddr = 5; wb_reg_write = 1; wb_waddr = 5; ex_rs = 5; ex_rt = 5; #1;
        check("fwd_a_exmem", 32'(fwd_a), 32'h2);
        check("fwd_b_exmem", 32'(fwd_b), 32'h2);
        mem_waddr = 0; wb_waddr = 0; #1;
        check("fwd_a_r0", 32'(fwd_a), 32'h0);
        wb_waddr = 5; #1;
        check("fwd_a_memwb", 32'(fwd_a), 32'h1);
        mem_reg_write = 0; mem_waddr = 5; ex_rt = 6; #1;
        check("fwd_a_wb_only", 32'(fwd_a), 32'h1);
        check("fwd_b_none", 32'(fwd_b), 32'h0);
        clr();

        mem_req = 1; dmem_ack = 1; #1;
        check("ack_same_en", 32'(en), 32'h1f);
        tick(); clr(); #1;
        check("ack_same_run", 32'(en), 32'h1f);

        mem_req = 1; ex_rs = 5; mem_reg_write = 1; mem_waddr = 5; #1;
        check("frz1_en", 32'(en), 32'h00);
        check("frz_fwd", 32'(fwd_a), 32'h2);
        tick();
        mem_req = 0; ex_branch_taken = 1; #1;
        check("frz2_en", 32'(en), 32'h00);
        check("frz2_fl", 32'(fl), 32'h0);
        tick(); ex_branch_taken = 0; #1;
        check("frz3_en", 32'(en), 32'h00);
        tick(); dmem_ack = 1; #1;
        check("ack_en", 32'(en), 32'h1f);
        tick(); clr(); #1;
        check("wait_stall", 32'(stall_cycles), 32'd6);
        check("wait_flush", 32'(flush_count), 32'd5);
        check("wait_run_en", 32'(en), 32'h1f);

        mem_req = 1;
        tick(); mem_req = 0;
        tick(); tick(); tick();
        check("tmo_w3", 32'(mem_timeout), 32'h0);
        tick();
        check("tmo_w4", 32'(mem_timeout), 32'h1);
        dmem_ack = 1;
        tick(); clr(); #1;
        check("tmo_sticky", 32'(mem_timeout), 32'h1);
        check("tmo_run_en", 32'(en), 32'h1f);
        check("tmo_stall", 32'(stall_cycles), 32'd11);

        mem_req = 1;
        for (int i = 0; i < 20; i++) tick();
        check("stall_sat", 32'(stall_cycles), 32'hf);
        dmem_ack = 1;
        tick(); clr(); ex_branch_taken = 1;
        for (int i = 0; i < 20; i++) tick();
        check("flush_sat", 32'(flush_count), 32'hf);
        clr();

        mem_req = 1;
        tick(); clr(); #1;
        check("pre_rst_frz", 32'(en), 32'h00);
        rst = 0; ex_rs = 5; mem_reg_write = 1; mem_waddr = 5; #1;
        check("mid_rst_en", 32'(en), 32'h1f);
        check("mid_rst_stall", 32'(stall_cycles), 32'h0);
        check("mid_rst_flush", 32'(flush_count), 32'h0);
        check("mid_rst_tmo", 32'(mem_timeout), 32'h0);
        check("mid_rst_fwd", 32'(fwd_a), 32'h0);
        clr();
        @(negedge clk);
        rst = 1;
        tick(); #1;
        check("post_rst_en", 32'(en), 32'h1f);
        check("post_rst_stall", 32'(stall_cycles), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
